// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC, fetches from a variable-latency
// instruction memory, issues each word to decode and retires it on ack.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc_cur,
  input  logic [15:0] pc_next,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic        halted,
  output logic        fetch_err,
  output logic [15:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_HALTED
  } state_t;

  // Counter value on the last WAIT cycle that may still receive data.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_tmo_cnt;
  logic [15:0] w_tmo_nxt;
  logic [15:0] r_pc;
  logic        r_imem_req;
  logic [15:0] r_instr;
  logic        r_instr_valid;
  logic        r_halted;
  logic        r_fetch_err;
  logic [15:0] r_retired;
  logic        w_is_halt;
  logic        w_timeout;

  assign w_is_halt = (r_instr[15:12] == HALT_OPCODE);
  assign w_timeout = (r_state == S_WAIT) && !imem_rvalid && (r_tmo_cnt == TMO_LAST);

  // NOTE: every output of an always_comb gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo_cnt;
    case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          w_state_nxt = S_WAIT;
          w_tmo_nxt   = 16'h0000;
        end
      end
      S_WAIT: begin
        // Data arriving on the final allowed cycle takes priority over the timeout.
        if (imem_rvalid)    w_state_nxt = S_ISSUE;
        else if (w_timeout) w_state_nxt = S_HALTED;
        else                w_tmo_nxt   = r_tmo_cnt + 16'h0001;
      end
      S_ISSUE: begin
        if (instr_ack) w_state_nxt = w_is_halt ? S_HALTED : S_REQ;
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_tmo_cnt     <= 16'h0000;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_instr       <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_retired     <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_imem_req <= (w_state_nxt == S_REQ);
      r_halted   <= (w_state_nxt == S_HALTED);
      if (w_timeout) r_fetch_err <= 1'b1;
      if ((r_state == S_WAIT) && imem_rvalid) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end
      if ((r_state == S_ISSUE) && instr_ack) begin
        r_instr_valid <= 1'b0;
        if (r_retired != 16'hFFFF) r_retired <= r_retired + 16'h0001;
        if (!w_is_halt) r_pc <= {pc_next[15:1], 1'b0};
      end
    end
  end

  assign pc_cur      = r_pc;
  assign imem_addr   = r_pc;
  assign imem_req    = r_imem_req;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign fetch_err   = r_fetch_err;
  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed fetch/ack sequences, with a
// monitor matching every new fetch request and issued instruction to queued expectations.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_cur;
  logic [15:0] pc_next = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic        halted;
  logic        fetch_err;
  logic [15:0] retired_cnt;

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_instr_q[$];

  fetch_sequencer #(
    .RESET_PC   (16'h0100),
    .HALT_OPCODE(4'hF),
    .TIMEOUT    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_cur     (pc_cur),
    .pc_next    (pc_next),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ack  (instr_ack),
    .halted     (halted),
    .fetch_err  (fetch_err),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Monitor: every rising imem_req / instr_valid must match the next queued expectation.
  logic prev_req = 1'b0;
  logic prev_valid = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1 && !prev_req) begin
        if (exp_addr_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_req: got addr %h, expected no request", imem_addr);
        end else begin
          check("fetch_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
        end
      end
      if (instr_valid === 1'b1 && !prev_valid) begin
        if (exp_instr_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_instr: got %h, expected no instruction", instr);
        end else begin
          check("issued_instr", 32'(instr), 32'(exp_instr_q.pop_front()));
        end
      end
      prev_req   = (imem_req === 1'b1);
      prev_valid = (instr_valid === 1'b1);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pc", 32'(pc_cur), 32'h0100);
    check("rst_flags", {28'h0, imem_req, instr_valid, halted, fetch_err}, 32'h0);
    check("rst_retired", 32'(retired_cnt), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    cyc();
    exp_addr_q.push_back(16'h0100);
    rst_n = 1'b1;
  endtask

  task automatic wait_req();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    if (!seen) begin
      n_total++;
      $display("FAIL wait_req: got no request within 20 cycles, expected imem_req=1");
    end
  endtask

  task automatic serve(input logic [15:0] addr, input int gnt_wait, input int rv_wait,
                       input logic [15:0] data);
    wait_req();
    for (int i = 0; i < gnt_wait; i++) begin
      check("req_hold", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, addr});
      cyc();
    end
    check("req_hold", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, addr});
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    for (int i = 1; i < rv_wait; i++) begin
      check("wait_no_req", 32'(imem_req), 32'h0);
      cyc();
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
  endtask

  task automatic ack(input logic [15:0] nxt, input bit expect_fetch, input logic [15:0] nxt_addr);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    if (!seen) begin
      n_total++;
      $display("FAIL wait_valid: got no instr_valid within 20 cycles, expected 1");
    end
    if (expect_fetch) exp_addr_q.push_back(nxt_addr);
    instr_ack = 1'b1;
    pc_next   = nxt;
    cyc();
    instr_ack = 1'b0;
    pc_next   = 16'h0000;
  endtask

  initial begin
    cyc();
    // Reset state and first fetch from RESET_PC
    do_reset();
    check("idle_no_req", 32'(imem_req), 32'h0);
    cyc();
    check("first_req", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0100});

    // Zero-wait memory, odd pc_next has bit0 cleared
    exp_instr_q.push_back(16'h1000);
    serve(16'h0100, 0, 1, 16'h1000);
    ack(16'h0102, 1'b1, 16'h0102);
    check("pc_after_ack1", 32'(pc_cur), 32'h0102);
    exp_instr_q.push_back(16'h2000);
    serve(16'h0102, 0, 1, 16'h2000);
    ack(16'h0105, 1'b1, 16'h0104);
    check("pc_after_ack2", 32'(pc_cur), 32'h0104);
    check("retired_2", 32'(retired_cnt), 32'h2);

    // Slow grant and slow data; instr held until ack
    exp_instr_q.push_back(16'h1234);
    serve(16'h0104, 3, 4, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      check("instr_hold", {15'h0, instr_valid, instr}, {15'h0, 1'b1, 16'h1234});
      cyc();
    end
    ack(16'h0200, 1'b1, 16'h0200);
    check("retired_3", 32'(retired_cnt), 32'h3);

    // HALT instruction stops the sequencer
    exp_instr_q.push_back(16'hF000);
    serve(16'h0200, 0, 1, 16'hF000);
    ack(16'h0300, 1'b0, 16'h0000);
    check("halted", {30'h0, halted, fetch_err}, {30'h0, 1'b1, 1'b0});
    check("halt_pc", 32'(pc_cur), 32'h0200);
    check("halt_retired", 32'(retired_cnt), 32'h4);
    for (int i = 0; i < 6; i++) begin
      imem_gnt    = 1'b1;
      imem_rvalid = 1'(i % 2);
      imem_rdata  = 16'h1111;
      instr_ack   = 1'(~i % 2);
      pc_next     = 16'h0400;
      cyc();
      check("halted_quiet", {29'h0, imem_req, instr_valid, halted}, 32'h1);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ack = 1'b0; pc_next = 16'h0000;
    check("halted_state", {retired_cnt, pc_cur}, {16'h0004, 16'h0200});
    check("halted_instr", 32'(instr), 32'hF000);

    // Fetch timeout: granted, no data for TIMEOUT cycles
    do_reset();
    wait_req();
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo_pending", {30'h0, halted, fetch_err}, 32'h0);
      cyc();
    end
    check("tmo_err", {30'h0, halted, fetch_err}, 32'h3);
    cyc();
    check("tmo_no_req", 32'(imem_req), 32'h0);

    // Data on the final timeout cycle wins
    do_reset();
    exp_instr_q.push_back(16'h3000);
    serve(16'h0100, 0, 4, 16'h3000);
    check("late_data", {29'h0, instr_valid, halted, fetch_err}, 32'h4);
    check("late_retired", 32'(retired_cnt), 32'h0);

    // Reset mid-WAIT; stale rvalid during IDLE ignored
    do_reset();
    wait_req();
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    cyc();
    do_reset();
    imem_rvalid = 1'b1;
    imem_rdata  = 16'hAAAA;
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    check("stale_ignored", {15'h0, instr_valid, instr}, 32'h0);
    exp_instr_q.push_back(16'h4000);
    serve(16'h0100, 1, 2, 16'h4000);
    ack(16'h0107, 1'b1, 16'h0106);
    check("fresh_pc", 32'(pc_cur), 32'h0106);
    check("fresh_retired", 32'(retired_cnt), 32'h1);

    cyc();
    cyc();
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'h0);
    check("instr_q_drained", 32'(exp_instr_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
